// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_tx slice
// Contents: shifter state enum, frame geometry, default parameter values.

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DATA_BITS          = 8;
  localparam int FRAME_BITS         = 10;
  localparam int DEFAULT_BAUD_DIV   = 217;  // 25 MHz / 115200
  localparam int DEFAULT_FIFO_DEPTH = 8;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - write/status bundle between I/O decode and uart_tx
// Signals:
//   wr_en, wr_data      byte write strobe and data (master -> slave)
//   ready               FIFO not full (slave -> master)
//   busy, level         activity and FIFO occupancy 0..FIFO_DEPTH
//   overflow            sticky dropped-write flag
//   txd                 serial line, idle high

interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);

  logic                          wr_en;
  logic [DATA_BITS-1:0]          wr_data;
  logic                          ready;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   level;
  logic                          overflow;
  logic                          txd;

  modport master (
    output wr_en,
    output wr_data,
    input  ready,
    input  busy,
    input  level,
    input  overflow,
    input  txd
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output ready,
    output busy,
    output level,
    output overflow,
    output txd
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous circular byte FIFO
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write request; ignored while full
//   pop, pop_data       read request; pop_data is the current head (show-ahead)
//   level, full, empty  occupancy status, all derived from the registered count

module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push that arrives while full.
  assign full     = (count == LVL_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide and wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter fed by a byte FIFO
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_tx_if.slave: wr_en/wr_data in; ready, busy, level, overflow, txd out
// Parameters:
//   BAUD_DIV    clock cycles per serial bit (>= 2)
//   FIFO_DEPTH  byte entries (power of two, >= 2)

module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int                CNT_W       = $clog2(BAUD_DIV);
  localparam int                LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  BAUD_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]        LAST_BIT    = 3'(DATA_BITS - 1);

  uart_state_t           state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [DATA_BITS-1:0]  shift;
  logic                  txd_q;
  logic                  overflow_q;

  logic [DATA_BITS-1:0]  pop_data;
  logic [LVL_W-1:0]      fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  bit_end;
  logic                  load;

  assign bit_end = (baud_cnt == '0);

  // A byte is taken from the FIFO either from IDLE or at the very end of a
  // stop bit; the latter chains frames back to back with no idle gap.
  assign load = !fifo_empty && ((state == IDLE) || (state == STOP && bit_end));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (load),
    .pop_data  (pop_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd_q    <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shift    <= pop_data;
            baud_cnt <= BAUD_RELOAD;
            txd_q    <= 1'b0;
            state    <= START;
          end else begin
            txd_q <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            txd_q    <= shift[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            shift    <= {1'b0, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              txd_q <= 1'b1;
              state <= STOP;
            end else begin
              // shift[1] is the bit that becomes shift[0] after this edge.
              txd_q   <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (load) begin
              shift    <= pop_data;
              baud_cnt <= BAUD_RELOAD;
              txd_q    <= 1'b0;
              state    <= START;
            end else begin
              txd_q <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          txd_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = !fifo_full;
  assign bus.busy     = !fifo_empty || (state != IDLE);
  assign bus.level    = fifo_level;
  assign bus.overflow = overflow_q;
  assign bus.txd      = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-timeline model

module tb_uart_tx;

  localparam int B  = 4;
  localparam int D  = 4;
  localparam int BD = 217;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_if #(.FIFO_DEPTH(D)) sif ();
  uart_tx_if #(.FIFO_DEPTH(8)) dif ();

  uart_tx #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  uart_tx dut_d (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model: queued bytes plus the timeline of the frame currently on the line
  int         cyc = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  bit         m_active = 0;
  int         m_start = 0;
  int         m_end = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovf = 0;
  logic       hist[$];
  int         d_edges[$];
  logic       d_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic exp_txd();
    int bi;
    if (!m_active) return 1'b1;
    bi = (cyc - m_start) / B;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return m_byte[bi-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input logic w, input logic [7:0] d, input logic r);
    int lvl;
    bit ld;
    if (r) begin
      m_q.delete();
      m_sent.delete();
      hist.delete();
      m_active = 0;
      m_ovf    = 0;
    end else begin
      lvl = m_q.size();
      ld  = (lvl > 0) && (!m_active || cyc == m_end);
      if (m_active && cyc == m_end) m_active = 0;
      if (ld) begin
        m_byte = m_q.pop_front();
        m_sent.push_back(m_byte);
        m_active = 1;
        m_start  = cyc;
        m_end    = cyc + 10 * B;
      end
      if (w) begin
        if (lvl < D) m_q.push_back(d);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic tick(input logic w, input logic [7:0] d, input logic r);
    rst         = r;
    sif.wr_en   = w;
    sif.wr_data = d;
    @(posedge clk);
    cyc++;
    model_edge(w, d, r);
    @(negedge clk);
    rst         = 1'b0;
    sif.wr_en   = 1'b0;
    sif.wr_data = 8'($urandom);
    dif.wr_en   = 1'b0;
    dif.wr_data = 8'($urandom);
    check("txd", sif.txd, exp_txd());
    check("level", sif.level, m_q.size());
    check("ready", sif.ready, m_q.size() < D);
    check("busy", sif.busy, (m_q.size() > 0) || m_active);
    check("overflow", sif.overflow, m_ovf);
    hist.push_back(sif.txd);
    if (dif.txd !== d_prev) begin
      d_edges.push_back(cyc);
      d_prev = dif.txd;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sif.busy !== 1'b0) && n < 3000) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    check({tag, "_drained"}, sif.busy, 0);
    repeat (2 * B) tick(1'b0, 8'h00, 1'b0);
  endtask

  // Decode the recorded line by sampling mid-bit after each falling start edge.
  task automatic check_decode(input string tag, input logic [7:0] exp[$]);
    logic [7:0] got[$];
    logic [7:0] v;
    int i;
    i = 0;
    while (i < hist.size()) begin
      if (hist[i] == 1'b0) begin
        check({tag, "_frame_complete"}, (i + 9 * B + B / 2) < hist.size(), 1);
        if ((i + 9 * B + B / 2) >= hist.size()) break;
        for (int b = 0; b < 8; b++) v[b] = hist[i + B * (b + 1) + B / 2];
        check({tag, "_stop_bit"}, hist[i + 9 * B + B / 2], 1);
        got.push_back(v);
        i += 9 * B + B / 2;
      end else begin
        i++;
      end
    end
    check({tag, "_count"}, got.size(), exp.size());
    for (int k = 0; k < got.size() && k < exp.size(); k++)
      check({tag, "_byte"}, got[k], exp[k]);
  endtask

  initial begin
    int         k;
    int         t_low;
    logic [7:0] b[6];
    logic [7:0] x, y, z;
    logic [7:0] exp_list[$];
    int         offs[6];

    rst         = 1'b1;
    sif.wr_en   = 1'b0;
    sif.wr_data = 8'h00;
    dif.wr_en   = 1'b0;
    dif.wr_data = 8'h00;

    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check("rst_txd", sif.txd, 1);
    check("rst_level", sif.level, 0);
    check("rst_ready", sif.ready, 1);
    check("rst_busy", sif.busy, 0);
    check("rst_overflow", sif.overflow, 0);
    check("rst_d_txd", dif.txd, 1);
    check("rst_d_busy", dif.busy, 0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);

    // single byte 0x55
    tick(1'b1, 8'h55, 1'b0);
    k = cyc;
    check("s1_level_after_write", sif.level, 1);
    t_low = -1;
    for (int j = 0; j < 60; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (j < 40) check("s1_line", sif.txd, (j / B) % 2);
      if (j == 0) check("s1_level_popped", sif.level, 0);
      if (sif.busy == 1'b0 && t_low < 0) t_low = cyc;
    end
    check("s1_busy_low_delay", t_low - (k + 1), 40);
    exp_list = '{8'h55};
    check_decode("s1", exp_list);
    tick(1'b0, 8'h00, 1'b1);

    // back-to-back 0x00, 0xFF
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'hFF, 1'b0);
    drain("s2");
    exp_list = '{8'h00, 8'hFF};
    check_decode("s2", exp_list);
    tick(1'b0, 8'h00, 1'b1);

    // write lands on the STOP-end cycle with one byte queued
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom);
    tick(1'b1, x, 1'b0);
    k = cyc;
    tick(1'b1, y, 1'b0);
    check("s4_level_y", sif.level, 1);
    while (cyc < k + 40) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, z, 1'b0);
    check("s4_level_same", sif.level, 1);
    check("s4_no_gap_start", sif.txd, 0);
    drain("s4");
    exp_list = '{x, y, z};
    check_decode("s4", exp_list);
    tick(1'b0, 8'h00, 1'b1);

    // fill and overflow
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, b[i], 1'b0);
      if (i == 4) begin
        check("s3_level_full", sif.level, 4);
        check("s3_ready_low", sif.ready, 0);
        check("s3_no_overflow_yet", sif.overflow, 0);
      end
    end
    check("s3_overflow_set", sif.overflow, 1);
    check("s3_level_held", sif.level, 4);
    drain("s3");
    check("s3_overflow_sticky", sif.overflow, 1);
    exp_list = '{b[0], b[1], b[2], b[3], b[4]};
    check_decode("s3", exp_list);

    // reset during DATA bit 3 (no reset beforehand so overflow is still set)
    tick(1'b1, 8'($urandom), 1'b0);
    k = cyc;
    while (cyc < k + 17) tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check("s5_txd_high", sif.txd, 1);
    check("s5_level", sif.level, 0);
    check("s5_busy", sif.busy, 0);
    check("s5_overflow_clr", sif.overflow, 0);
    tick(1'b1, 8'hA5, 1'b0);
    drain("s5");
    exp_list = '{8'hA5};
    check_decode("s5", exp_list);
    tick(1'b0, 8'h00, 1'b1);

    // random traffic: sparse and bursty phases
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 120; j++) begin
        if (p % 2 == 0) tick($urandom_range(0, 15) == 0, 8'($urandom), 1'b0);
        else tick($urandom_range(0, 2) != 0, 8'($urandom), 1'b0);
      end
    end
    drain("s6");
    exp_list = m_sent;
    check_decode("s6", exp_list);
    tick(1'b0, 8'h00, 1'b1);

    // default parameters: 0x41 at BAUD_DIV=217
    d_edges.delete();
    dif.wr_en   = 1'b1;
    dif.wr_data = 8'h41;
    tick(1'b0, 8'h00, 1'b0);
    k = cyc;
    check("s7_level", dif.level, 1);
    t_low = -1;
    for (int j = 0; j < 10 * BD + 20; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (dif.busy == 1'b0 && t_low < 0) t_low = cyc;
    end
    offs = '{0, BD, 2 * BD, 7 * BD, 8 * BD, 9 * BD};
    check("s7_edge_count", d_edges.size(), 6);
    for (int i = 0; i < 6 && i < d_edges.size(); i++)
      check("s7_edge_time", d_edges[i] - (k + 1), offs[i]);
    check("s7_frame_len", t_low - (k + 1), 10 * BD);
    check("s7_txd_idle", dif.txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that drives the board's `ftdi_txd` line from bytes the processor writes through a memory-mapped I/O register.
- Sits downstream of the SOC address decode. Accepts one byte per write strobe into a small FIFO, then serialises each byte as 8N1 (1 start, 8 data LSB-first, 1 stop).
- Lets firmware queue short strings without polling per bit.

Parameters:
- BAUD_DIV, 217, clock cycles per serial bit (25 MHz / 115200). Legal range ≥ 2.
- FIFO_DEPTH, 8, byte entries. Power of two, ≥ 2.

Ports:
- clk  input  1  system clock (post-gearbox clock from Clockworks)
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe from I/O decode. One byte per asserted cycle.
- wr_data  input  8  byte to queue. Sampled when wr_en && ready.
- ready  output  1  FIFO not full. Combinational from registered count.
- busy  output  1  FIFO non-empty OR shifter not IDLE
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH
- overflow  output  1  sticky. Set when wr_en is high while ready is low. Cleared only by rst.
- txd  output  1  serial line, registered, idle high

Behaviour:
- Reset (rst high at a rising edge), values after that edge:
  - txd=1, level=0, ready=1, busy=0, overflow=0.
  - Shifter returns to IDLE; baud counter and bit index cleared.
  - Applies mid-frame: the frame is truncated and the line returns high at that edge.
- FIFO (circular buffer, rd/wr pointers of $clog2(FIFO_DEPTH) bits, wrap naturally):
  - Write accepted iff wr_en && ready.
  - Pop occurs only on shifter load (see below).
  - Simultaneous accepted write and pop: level unchanged, both pointers advance.
  - Write while full: data dropped, level unchanged, overflow←1. A pop in that same cycle does not rescue the write.
  - Write while empty: no same-cycle pop, since the load condition uses registered level.
- Shifter FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If level≠0, pop the head byte into an 8-bit shift register, load baud counter with BAUD_DIV-1, set txd←0, go to START.
  - START / DATA / STOP: each bit lasts exactly BAUD_DIV cycles. The baud counter decrements each cycle; the bit advances when it reaches 0, then reloads BAUD_DIV-1.
  - START → DATA: txd←shift[0], bit index←0.
  - DATA: on each bit end, shift right. After bit index 7 ends, txd←1 and go to STOP; otherwise txd←next bit.
  - STOP end: if level≠0, pop and load directly into START (txd←0) with no idle gap. Otherwise go to IDLE.
- Latency: write accepted at edge k → level=1 after edge k; txd falls at edge k+1.
- Frame length: exactly 10×BAUD_DIV cycles, start-edge to start-edge, for back-to-back bytes.
- busy goes low on the cycle the FSM enters IDLE with level=0.
- wr_data is captured only on accept; later changes to wr_data never alter queued bytes.

Decomposition:
- Shared package `uart_pkg`:
  - state enum {IDLE, START, DATA, STOP} (2 bits)
  - constants DATA_BITS=8, FRAME_BITS=10
  - default BAUD_DIV value
- One sub-module, `uart_tx_fifo` (synchronous circular FIFO with push/pop/level/full/empty, FIFO_DEPTH parameter).
- The FSM, baud counter and shift register stay in uart_tx.

Test Plan (BAUD_DIV=4, FIFO_DEPTH=4 unless stated):
- Single byte: write 0x55 at edge k → txd low at edge k+1. Line pattern 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles. busy low 40 cycles after k+1. level returns 0 at edge k+1.
- Back-to-back: write 0x00 then 0xFF on consecutive cycles → two contiguous 40-cycle frames with no idle cycle between STOP and the second START. Decoded bytes 0x00, 0xFF.
- Full/overflow: with the shifter busy, write 5 bytes in consecutive cycles (first already popped) → level reaches 4, ready=0, and the 6th write sets overflow=1. The dropped byte never appears on txd; all others appear in order.
- Simultaneous push/pop: time a write to the STOP-end cycle with level=1 → level stays 1, and both bytes are transmitted in order.
- Reset mid-frame: assert rst during DATA bit 3 for one cycle → txd=1 after that edge. level=0, busy=0, overflow=0. A following write of 0xA5 transmits a clean frame.
- Default parameters (BAUD_DIV=217): write 0x41 → each bit held exactly 217 cycles. Total frame 2170 cycles.
